// File: rtl/secded_codec_pipe.sv
// secded_codec_pipe: two-stage pipelined SECDED encoder/decoder with valid/ready handshake and saturating error counters
module secded_codec_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W = 16,
    localparam int R = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int CW = DATA_W + R + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             MODE,
    input  logic [CW-1:0]    IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CW-1:0]    OUT,
    output logic             SE,
    output logic             DE,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] CE_CNT,
    output logic [CNT_W-1:0] UE_CNT
);
    localparam int N = DATA_W + R;

    logic              s1_valid, s1_mode, s1_adv, hs;
    logic [CW-1:0]     s1_in, res;
    logic              res_se, res_de, p_err, in_range;
    logic [DATA_W-1:0] d;
    logic [R-1:0]      c, s;

    // data bits occupy the non-power-of-two positions 1..N in ascending order
    function automatic logic [R-1:0] check(input logic [DATA_W-1:0] x);
        logic [R-1:0] y;
        int j;
        y = '0;
        j = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin
                for (int i = 0; i < R; i++)
                    if (p[i]) y[i] = y[i] ^ x[j];
                j++;
            end
        return y;
    endfunction

    function automatic logic [DATA_W-1:0] fix(input logic [DATA_W-1:0] x, input logic [R-1:0] syn);
        logic [DATA_W-1:0] y;
        int j;
        y = x;
        j = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin
                if (p == int'(syn)) y[j] = ~y[j];
                j++;
            end
        return y;
    endfunction

    always_comb begin
        d = s1_in[DATA_W-1:0];
        c = check(d);
        s = c ^ s1_in[N-1:DATA_W];
        p_err = ^s1_in;
        in_range = int'(s) <= N;
        res_se = s1_mode && p_err && in_range;
        res_de = s1_mode && (p_err ? !in_range : s != '0);
        res = s1_mode ? {p_err, s, p_err ? fix(d, s) : d} : {^{c, d}, c, d};
    end

    assign s1_adv = !OUT_VALID || OUT_READY;
    assign IN_READY = !RST && (!s1_valid || s1_adv);
    assign hs = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK)
        if (RST) begin
            s1_valid <= 1'b0;
            s1_mode <= 1'b0;
            s1_in <= '0;
            OUT_VALID <= 1'b0;
            OUT <= '0;
            SE <= 1'b0;
            DE <= 1'b0;
        end else begin
            if (IN_READY) begin
                s1_valid <= IN_VALID;
                s1_mode <= MODE;
                s1_in <= IN;
            end
            if (s1_adv) begin
                OUT_VALID <= s1_valid;
                if (s1_valid) begin
                    OUT <= res;
                    SE <= res_se;
                    DE <= res_de;
                end
            end
        end

    always_ff @(posedge CLK)
        if (RST || CNT_CLR) begin
            CE_CNT <= '0;
            UE_CNT <= '0;
        end else if (hs) begin
            if (SE && !(&CE_CNT)) CE_CNT <= CE_CNT + 1'b1;
            if (DE && !(&UE_CNT)) UE_CNT <= UE_CNT + 1'b1;
        end
endmodule

// File: tb/tb_secded_codec_pipe.sv
// tb_secded_codec_pipe: directed checks of encode/decode vectors, back-pressure, counter saturation/clear and reset
module tb_secded_codec_pipe;
    logic        CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0, MODE = 1'b0, OUT_READY = 1'b1, CNT_CLR = 1'b0;
    logic [71:0] IN = '0;
    logic        IN_READY, OUT_VALID, SE, DE;
    logic [71:0] OUT;
    logic [15:0] CE_CNT, UE_CNT;
    logic        b_in_ready, b_out_valid, b_se, b_de;
    logic [71:0] b_out;
    logic [1:0]  b_ce, b_ue;
    logic [71:0] exp_bp [3];
    int          n_chk = 0, n_fail = 0, got;

    always #5 CLK = ~CLK;

    secded_codec_pipe dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .MODE(MODE), .IN(IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .SE(SE), .DE(DE),
        .CNT_CLR(CNT_CLR), .CE_CNT(CE_CNT), .UE_CNT(UE_CNT)
    );

    secded_codec_pipe #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(b_in_ready), .MODE(MODE), .IN(IN),
        .OUT_VALID(b_out_valid), .OUT_READY(OUT_READY), .OUT(b_out), .SE(b_se), .DE(b_de),
        .CNT_CLR(CNT_CLR), .CE_CNT(b_ce), .UE_CNT(b_ue)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // called at a negedge with an empty input stage; returns at the negedge where the result is valid
    task automatic run(input logic m, input logic [71:0] w);
        int k;
        MODE = m;
        IN = w;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        for (k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (OUT_VALID) break;
        end
        chk("out_valid_arrives", 72'(OUT_VALID), 72'd1);
        chk("latency", 72'(k), 72'd0);
    endtask

    initial begin
        exp_bp[0] = 72'h83_0000000000000001;
        exp_bp[1] = 72'h85_0000000000000002;
        exp_bp[2] = 72'h06_0000000000000003;
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", 72'(OUT_VALID), 72'd0);
        chk("rst_in_ready", 72'(IN_READY), 72'd0);
        chk("rst_out", OUT, 72'd0);
        chk("rst_se_de", 72'({SE, DE}), 72'd0);
        chk("rst_cnt", 72'({CE_CNT, UE_CNT}), 72'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_in_ready", 72'(IN_READY), 72'd1);

        run(1'b0, 72'h0);
        chk("enc_0", OUT, 72'h0);
        chk("enc_0_flags", 72'({SE, DE}), 72'd0);
        run(1'b0, 72'hFF_0000000000000001);
        chk("enc_1", OUT, 72'h83_0000000000000001);
        run(1'b0, 72'h2);
        chk("enc_2", OUT, 72'h85_0000000000000002);
        run(1'b0, 72'h00_8000000000000000);
        chk("enc_msb", OUT, 72'hC7_8000000000000000);

        run(1'b1, 72'h83_0000000000000000);
        chk("dec_d0", OUT, 72'h83_0000000000000001);
        chk("dec_d0_flags", 72'({SE, DE}), 72'd2);
        @(negedge CLK);
        chk("ce_1", 72'(CE_CNT), 72'd1);
        chk("ue_0", 72'(UE_CNT), 72'd0);
        run(1'b1, 72'h00_0000000000000003);
        chk("dec_double", OUT, 72'h06_0000000000000003);
        chk("dec_double_flags", 72'({SE, DE}), 72'd1);
        @(negedge CLK);
        chk("ue_1", 72'(UE_CNT), 72'd1);
        run(1'b1, 72'h80_0000000000000000);
        chk("dec_p", OUT, 72'h80_0000000000000000);
        chk("dec_p_flags", 72'({SE, DE}), 72'd2);
        run(1'b1, 72'h01_0000000000000000);
        chk("dec_c0", OUT, 72'h81_0000000000000000);
        chk("dec_c0_flags", 72'({SE, DE}), 72'd2);
        run(1'b1, 72'h7F_0000000000000000);
        chk("dec_s127", OUT, 72'hFF_0000000000000000);
        chk("dec_s127_flags", 72'({SE, DE}), 72'd1);
        run(1'b1, 72'h00_8000000000000000);
        chk("dec_msb", OUT, 72'hC7_0000000000000000);
        chk("dec_msb_flags", 72'({SE, DE}), 72'd2);
        run(1'b1, 72'h83_0000000000000001);
        chk("dec_clean", OUT, 72'h00_0000000000000001);
        chk("dec_clean_flags", 72'({SE, DE}), 72'd0);
        run(1'b1, 72'h01_0000000000000000);
        @(negedge CLK);
        chk("ce_5", 72'(CE_CNT), 72'd5);
        chk("ue_2", 72'(UE_CNT), 72'd2);
        chk("ce_sat", 72'(b_ce), 72'd3);
        chk("ue_small", 72'(b_ue), 72'd2);

        run(1'b1, 72'h01_0000000000000000);
        CNT_CLR = 1'b1;
        @(negedge CLK);
        CNT_CLR = 1'b0;
        chk("clr_ce", 72'(CE_CNT), 72'd0);
        chk("clr_ce_small", 72'(b_ce), 72'd0);
        chk("clr_ue", 72'(UE_CNT), 72'd0);

        OUT_READY = 1'b0;
        MODE = 1'b0;
        IN = 72'h1;
        IN_VALID = 1'b1;
        #1 chk("bp_ready_a", 72'(IN_READY), 72'd1);
        @(negedge CLK);
        chk("bp_ready_b", 72'(IN_READY), 72'd1);
        IN = 72'h2;
        @(negedge CLK);
        IN = 72'h3;
        for (int k = 0; k < 4; k++) begin
            chk("bp_stall", 72'(IN_READY), 72'd0);
            chk("bp_valid", 72'(OUT_VALID), 72'd1);
            chk("bp_hold", OUT, exp_bp[0]);
            if (k < 3) @(negedge CLK);
        end
        OUT_READY = 1'b1;
        #1 chk("bp_resume", 72'(IN_READY), 72'd1);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        got = 1;
        for (int k = 0; k < 10 && got < 3; k++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                chk("bp_order", OUT, exp_bp[got]);
                got++;
            end
        end
        chk("bp_count", 72'(got), 72'd3);
        @(negedge CLK);
        chk("bp_no_dup", 72'(OUT_VALID), 72'd0);

        MODE = 1'b1;
        IN = 72'h00_0000000000000003;
        IN_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        chk("mid_valid", 72'(OUT_VALID), 72'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_valid", 72'(OUT_VALID), 72'd0);
        chk("mid_rst_ready", 72'(IN_READY), 72'd0);
        chk("mid_rst_ue", 72'(UE_CNT), 72'd0);
        RST = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("post_rst_empty", 72'(OUT_VALID), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
